// File: rtl/ser_ctrl8.sv
// ser_ctrl8: sequences an external 8-bit shift register for one-byte serial TX or RX.
// Define SER_CTRL8_PARITY_EN to add an even-parity bit phase after the data bits.
module ser_ctrl8 #(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic       START,
    input  logic       OP,
    input  logic       DIR,
    input  logic [7:0] TX_DATA,
    input  logic       SER_IN,
    input  logic [7:0] Q8,
    input  logic       S_OUT8,
    output logic       ENB8,
    output logic       DIR8,
    output logic [1:0] MODO8,
    output logic [7:0] D8,
    output logic       S_IN8,
    output logic       SER_OUT,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RX_DATA,
    output logic       PAR_ERR
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
`ifdef SER_CTRL8_PARITY_EN
        PARITY,
`endif
        FIN
    } state_t;
    state_t state, nextState;
    logic [2:0] cnt;
    logic opLat, dirLat;
    logic [7:0] txLat, rxData;
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            opLat  <= 1'b0;
            dirLat <= 1'b0;
            txLat  <= 8'd0;
            rxData <= 8'd0;
        end else begin
            state <= nextState;
            cnt   <= (state == SHIFT) ? cnt + 3'd1 : 3'd0;
            if (state == IDLE && START) begin
                opLat  <= OP;
                dirLat <= DIR;
                txLat  <= TX_DATA;
            end
            // Q8 is final during FIN: the last shift edge has already landed
            if (state == FIN && opLat) rxData <= Q8;
        end
    end
`ifdef SER_CTRL8_PARITY_EN
    logic parErr;
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) parErr <= 1'b0;
        else if (state == PARITY && opLat) parErr <= (^Q8) != SER_IN;
    end
    assign PAR_ERR = parErr;
`else
    assign PAR_ERR = 1'b0;
`endif
    assign RX_DATA = rxData;
    always_comb begin
        nextState = state;
        ENB8      = 1'b0;
        MODO8     = 2'b00;
        DIR8      = dirLat;
        D8        = txLat;
        S_IN8     = 1'b0;
        SER_OUT   = IDLE_LEVEL;
        BUSY      = state != IDLE;
        DONE      = 1'b0;
        case (state)
            IDLE: nextState = START ? (OP ? SHIFT : LOAD) : IDLE;
            LOAD: begin
                nextState = SHIFT;
                ENB8      = 1'b1;
                MODO8     = 2'b10;
            end
            SHIFT: begin
`ifdef SER_CTRL8_PARITY_EN
                nextState = (cnt == 3'd7) ? PARITY : SHIFT;
`else
                nextState = (cnt == 3'd7) ? FIN : SHIFT;
`endif
                ENB8    = 1'b1;
                S_IN8   = opLat ? SER_IN : 1'b0;
                SER_OUT = opLat ? IDLE_LEVEL : S_OUT8;
            end
`ifdef SER_CTRL8_PARITY_EN
            PARITY: begin
                nextState = FIN;
                SER_OUT   = opLat ? IDLE_LEVEL : ^txLat;
            end
`endif
            FIN: begin
                nextState = IDLE;
                DONE      = 1'b1;
            end
            default: nextState = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ser_ctrl8.sv
// tb_ser_ctrl8: directed checks of ser_ctrl8 driving a behavioural 8-bit shift register.
// Default build only: parity phase disabled, so PAR_ERR must stay 0.
module tb_ser_ctrl8;
    logic CLK, RESET_L, START, OP, DIR, SER_IN, S_OUT8;
    logic [7:0] TX_DATA, Q8, D8, RX_DATA;
    logic ENB8, DIR8, S_IN8, SER_OUT, BUSY, DONE, PAR_ERR;
    logic [1:0] MODO8;
    int tests = 0, fails = 0, doneCnt = 0;

    ser_ctrl8 dut (
        .CLK(CLK), .RESET_L(RESET_L), .START(START), .OP(OP), .DIR(DIR),
        .TX_DATA(TX_DATA), .SER_IN(SER_IN), .Q8(Q8), .S_OUT8(S_OUT8),
        .ENB8(ENB8), .DIR8(DIR8), .MODO8(MODO8), .D8(D8), .S_IN8(S_IN8),
        .SER_OUT(SER_OUT), .BUSY(BUSY), .DONE(DONE), .RX_DATA(RX_DATA), .PAR_ERR(PAR_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // register model: DIR8=1 shifts toward MSB (serial out from bit 7), DIR8=0 toward LSB
    assign S_OUT8 = DIR8 ? Q8[7] : Q8[0];
    always @(posedge CLK)
        if (ENB8) begin
            if (MODO8 == 2'b10) Q8 <= D8;
            else if (MODO8 == 2'b00) Q8 <= DIR8 ? {Q8[6:0], S_IN8} : {S_IN8, Q8[7:1]};
        end
    always @(posedge CLK) if (DONE === 1'b1) doneCnt <= doneCnt + 1;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, " busy"}, BUSY, 0);
        chk({tag, " done"}, DONE, 0);
        chk({tag, " enb"}, ENB8, 0);
        chk({tag, " modo"}, MODO8, 0);
        chk({tag, " sin"}, S_IN8, 0);
        chk({tag, " serout"}, SER_OUT, 1);
        chk({tag, " parerr"}, PAR_ERR, 0);
    endtask

    // full TX; START is re-asserted in cycles p1/p2 and must be ignored
    task automatic txRun(input logic [7:0] data, input logic d, input int p1, input int p2);
        int d0;
        d0 = doneCnt;
        OP = 1'b0; DIR = d; TX_DATA = data; START = 1'b1;
        tick;
        START = 1'b0; TX_DATA = ~data; DIR = ~d;
        chk("tx load enb", ENB8, 1);
        chk("tx load modo", MODO8, 2'b10);
        chk("tx load d8", D8, data);
        chk("tx load busy", BUSY, 1);
        chk("tx load serout", SER_OUT, 1);
        START = (p1 == 1 || p2 == 1);
        tick;
        for (int k = 0; k < 8; k++) begin
            chk("tx shift enb", ENB8, 1);
            chk("tx shift modo", MODO8, 0);
            chk("tx shift dir8", DIR8, d);
            chk("tx shift sin", S_IN8, 0);
            chk("tx shift done", DONE, 0);
            chk("tx shift serout", SER_OUT, d ? data[7-k] : data[k]);
            chk("tx shift d8", D8, data);
            START = (p1 == k + 2 || p2 == k + 2);
            tick;
        end
        START = 1'b0;
        chk("tx fin done", DONE, 1);
        chk("tx fin busy", BUSY, 1);
        chk("tx fin enb", ENB8, 0);
        chk("tx fin serout", SER_OUT, 1);
        tick;
        chk("tx after busy", BUSY, 0);
        chk("tx after done", DONE, 0);
        chk("tx done pulses", 8'(doneCnt - d0), 1);
    endtask

    // full RX; pat[7] is the first serial bit
    task automatic rxRun(input logic [7:0] pat, input logic d, input logic [7:0] exp, input logic [7:0] prev);
        OP = 1'b1; DIR = d; START = 1'b1;
        tick;
        START = 1'b0; OP = 1'b0;
        for (int k = 0; k < 8; k++) begin
            SER_IN = pat[7-k];
            #1;
            chk("rx shift sin", S_IN8, pat[7-k]);
            chk("rx shift enb", ENB8, 1);
            chk("rx shift modo", MODO8, 0);
            chk("rx shift busy", BUSY, 1);
            chk("rx shift serout", SER_OUT, 1);
            tick;
        end
        SER_IN = 1'b0;
        chk("rx fin done", DONE, 1);
        chk("rx fin enb", ENB8, 0);
        chk("rx fin hold", RX_DATA, prev);
        tick;
        chk("rx data", RX_DATA, exp);
        chk("rx after busy", BUSY, 0);
        chk("rx after done", DONE, 0);
    endtask

    initial begin
        RESET_L = 1'b0; START = 1'b0; OP = 1'b0; DIR = 1'b0; TX_DATA = 8'h00; SER_IN = 1'b0;
        #1;
        chkIdle("reset");
        tick;
        tick;
        chkIdle("reset clocked");
        chk("reset rxdata", RX_DATA, 8'h00);
        chk("reset d8", D8, 8'h00);
        RESET_L = 1'b1;
        tick;
        chkIdle("idle");
        txRun(8'hA5, 1'b1, 0, 0);
        txRun(8'h3C, 1'b0, 3, 9);
        rxRun(8'b10110010, 1'b1, 8'hB2, 8'h00);
        txRun(8'h81, 1'b1, 0, 0);
        chk("rx hold over tx", RX_DATA, 8'hB2);
        rxRun(8'b10110010, 1'b0, 8'h4D, 8'hB2);
        begin
            int d0;
            d0 = doneCnt;
            OP = 1'b0; DIR = 1'b1; TX_DATA = 8'h5A; START = 1'b1;
            tick;
            START = 1'b0;
            repeat (4) tick;
            chk("pre-abort enb", ENB8, 1);
            RESET_L = 1'b0;
            #1;
            chkIdle("abort");
            chk("abort rxdata", RX_DATA, 8'h00);
            chk("abort d8", D8, 8'h00);
            repeat (12) tick;
            chk("abort no done", 8'(doneCnt - d0), 0);
            RESET_L = 1'b1;
            tick;
            chkIdle("after abort");
        end
        txRun(8'h96, 1'b0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ser_ctrl8.md
SER_CTRL8 -- requirements
Module: ser_ctrl8

Interface
REQ-001 The block SHALL have parameter IDLE_LEVEL, default 1'b1, which sets the SER_OUT level when not shifting.
REQ-002 The block SHALL have port CLK, input, 1, the sole clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RESET_L, input, 1, which is an asynchronous, active-low reset.
REQ-004 The block SHALL have port START, input, 1, an operation request sampled in IDLE.
REQ-005 The block SHALL have port OP, input, 1: 0 = transmit (TX), 1 = receive (RX); latched at START.
REQ-006 The block SHALL have port DIR, input, 1, the shift direction forwarded to the register; latched at START.
REQ-007 The block SHALL have port TX_DATA, input, 8, the byte to transmit; latched at START.
REQ-008 The block SHALL have port SER_IN, input, 1, the serial receive line.
REQ-009 The block SHALL have port Q8, input, 8, the parallel contents of the controlled shift register.
REQ-010 The block SHALL have port S_OUT8, input, 1, the serial output of the controlled register.
REQ-011 The block SHALL have ports ENB8 (1), DIR8 (1), MODO8 (2), D8 (8) and S_IN8 (1), all outputs driving the register.
REQ-012 The block SHALL have port SER_OUT, output, 1, the serial transmit line.
REQ-013 The block SHALL have ports BUSY (1), DONE (1), RX_DATA (8) and PAR_ERR (1), all status outputs.

Function
REQ-014 The state machine SHALL have states IDLE, LOAD, SHIFT, PARITY (macro only) and FIN.
- MODO8 encoding: 2'b10 = parallel load, 2'b00 = shift.
REQ-015 IDLE: ENB8=0, BUSY=0; START=1 latches OP/DIR/TX_DATA, then goes to LOAD (TX) or SHIFT (RX).
REQ-016 LOAD lasts 1 cycle with ENB8=1, MODO8=2'b10, D8=latched TX_DATA, BUSY=1.
REQ-017 SHIFT lasts exactly 8 cycles with ENB8=1, MODO8=2'b00, DIR8=latched DIR, and a 3-bit counter 0..7; it exits on count 7.
REQ-018 In TX SHIFT, SER_OUT SHALL equal S_OUT8 (combinational); outside SHIFT/PARITY, SER_OUT SHALL equal IDLE_LEVEL.
REQ-019 In RX SHIFT, S_IN8 SHALL equal SER_IN; in TX, S_IN8 SHALL be 0.
REQ-020 FIN lasts 1 cycle with DONE=1, ENB8=0, BUSY=1; in RX, RX_DATA <= Q8 on the FIN edge; FIN then goes to IDLE.
REQ-021 Latency without the macro: DONE SHALL be high in the 10th cycle after START is sampled for TX, and in the 9th cycle for RX.
REQ-022 START SHALL be ignored whenever the state is not IDLE; back-to-back requests are accepted on the cycle after FIN.
REQ-023 RX_DATA SHALL hold its value until the next RX FIN.
REQ-024 D8 SHALL be driven with the latched TX_DATA in all states.

Reset
REQ-025 When RESET_L=0, state SHALL be IDLE, the counter 0, and latched regs, RX_DATA and PAR_ERR 0.
REQ-026 During reset, BUSY, DONE, ENB8 and S_IN8 SHALL be 0, MODO8 SHALL be 2'b00, and SER_OUT SHALL be IDLE_LEVEL.
REQ-027 Reset asserted mid-operation SHALL abort immediately with no DONE pulse; operation resumes from IDLE on the first CLK edge after release.

Configuration
REQ-028 Macro SER_CTRL8_PARITY_EN: when defined, SHIFT SHALL exit to PARITY (1 cycle, ENB8=0) before FIN.
- TX: SER_OUT = ^TX_DATA (even parity).
- RX: PAR_ERR <= (^Q8 != SER_IN), held until the next RX FIN.
- Latency +1 cycle.
REQ-029 Without SER_CTRL8_PARITY_EN, the PARITY state SHALL NOT exist, PAR_ERR SHALL be tied 0, and latency SHALL be as in REQ-021.

Verification
REQ-030 Reset, then TX 8'hA5 with DIR=1 -> 1 LOAD cycle with MODO8=10 and D8=A5, 8 SHIFT cycles with SER_OUT tracking S_OUT8, DONE in cycle 10.
REQ-031 RX with SER_IN pattern 1,0,1,1,0,0,1,0 against a register model -> RX_DATA equals model Q8 at FIN, BUSY low afterwards.
REQ-032 START pulsed in cycles 3 and 9 of a TX -> ignored, exactly one DONE; START in the cycle after FIN is accepted.
REQ-033 RESET_L low in SHIFT cycle 4 -> all outputs at reset values immediately, no DONE, next TX completes normally.
REQ-034 With SER_CTRL8_PARITY_EN: TX 8'h07 -> parity bit 1; RX of 8'h07 with parity bit 0 -> PAR_ERR=1, DONE in cycle 10.
